// File: rtl/linha_envase_pkg.sv
// Shared state encoding and default timing constants for the bottling-station sequencer.
// No logic of its own; imported by the sequencer and its timer.
package linha_envase_pkg;

   localparam int SETTLE_PADRAO  = 4;
   localparam int TIMEOUT_PADRAO = 1000;

   localparam logic [2:0] COD_PARADO     = 3'd0;
   localparam logic [2:0] COD_AVANCANDO  = 3'd1;
   localparam logic [2:0] COD_ASSENTANDO = 3'd2;
   localparam logic [2:0] COD_ENCHENDO   = 3'd3;
   localparam logic [2:0] COD_LIBERANDO  = 3'd4;
   localparam logic [2:0] COD_LOTE       = 3'd5;
   localparam logic [2:0] COD_FALHA      = 3'd6;

   typedef enum logic [2:0] {
      PARADO     = COD_PARADO,
      AVANCANDO  = COD_AVANCANDO,
      ASSENTANDO = COD_ASSENTANDO,
      ENCHENDO   = COD_ENCHENDO,
      LIBERANDO  = COD_LIBERANDO,
      LOTE       = COD_LOTE,
      FALHA      = COD_FALHA
   } estado_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/temporizador_envase.sv
// Clearable up-counter with terminal compare; shared by settle and fill-timeout phases.
// Latency: terminal is combinational from the registered count. No backpressure.
module temporizador_envase #(
   parameter int W = 4
) (
   input  logic         CLOCK,
   input  logic         RESET,
   input  logic         limpa,
   input  logic         conta,
   input  logic [W-1:0] limite,
   output logic         terminal
);

   logic [W-1:0] contador;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET)
         contador <= '0;
      else if (limpa)
         contador <= '0;
      else if (conta)
         contador <= contador + 1'b1;
   end

   assign terminal = (contador == limite);

endmodule

// File: rtl/controle_linha_envase.sv
// Bottling-station sequencer: conveyor, settle, fill release, eject, crate count.
// Moore outputs, one cycle from inputs to state; no backpressure. Optional FILL_TIMEOUT_EN adds FALHA.
module controle_linha_envase
   import linha_envase_pkg::*;
#(
   parameter int BATCH_SIZE     = 12,
   parameter int SETTLE_CYCLES  = SETTLE_PADRAO,
   parameter int TIMEOUT_CYCLES = TIMEOUT_PADRAO,
   parameter int CNT_W          = 4
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             START,
   input  logic             STOP,
   input  logic             SENSOR_POSICAO,
   input  logic             GARRAFA_CHEIA,
   output logic             MOTOR_ESTEIRA,
   output logic             LIBERA_ENCHIMENTO,
   output logic             OCUPADO,
   output logic [CNT_W-1:0] CONTAGEM,
   output logic             LOTE_COMPLETO,
   output logic             ALARME
);

   localparam int TW = $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
   localparam logic [CNT_W-1:0] LOTE_CHEIO = CNT_W'(BATCH_SIZE);

   estado_t        estado, prox_estado;
   logic           stop_pend;
   logic           terminal;
   logic           conta_tempo;
   logic [TW-1:0]  limite;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET)
         estado <= PARADO;
      else
         estado <= prox_estado;
   end

   always_comb begin
      prox_estado = estado;
      case (estado)
         PARADO:
            if (START && !STOP) prox_estado = AVANCANDO;
         AVANCANDO:
            if (STOP)                prox_estado = PARADO;
            else if (SENSOR_POSICAO) prox_estado = ASSENTANDO;
         ASSENTANDO:
            if (!SENSOR_POSICAO) prox_estado = AVANCANDO;
            else if (terminal)   prox_estado = ENCHENDO;
         ENCHENDO:
            if (GARRAFA_CHEIA)        prox_estado = LIBERANDO;
            else if (!SENSOR_POSICAO) prox_estado = AVANCANDO;
`ifdef FILL_TIMEOUT_EN
            else if (terminal)        prox_estado = FALHA;
`endif
         LIBERANDO:
            if (!SENSOR_POSICAO) begin
               // A full crate is always closed out before honouring a pending stop.
               if (CONTAGEM == LOTE_CHEIO) prox_estado = LOTE;
               else if (stop_pend)         prox_estado = PARADO;
               else                        prox_estado = AVANCANDO;
            end
         LOTE:
            prox_estado = PARADO;
`ifdef FILL_TIMEOUT_EN
         FALHA:
            if (STOP) prox_estado = PARADO;
`endif
         default:
            prox_estado = PARADO;
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         stop_pend <= 1'b0;
         CONTAGEM  <= '0;
      end else begin
         if (prox_estado == PARADO)
            stop_pend <= 1'b0;
         else if (STOP && (estado == ASSENTANDO || estado == ENCHENDO || estado == LIBERANDO))
            stop_pend <= 1'b1;

         if (estado == LOTE)
            CONTAGEM <= '0;
         else if (estado == ENCHENDO && prox_estado == LIBERANDO && CONTAGEM < LOTE_CHEIO)
            CONTAGEM <= CONTAGEM + 1'b1;
      end
   end

   // Every state change restarts the timer, so each phase starts counting from zero.
`ifdef FILL_TIMEOUT_EN
   assign conta_tempo = (estado == ASSENTANDO) || (estado == ENCHENDO);
`else
   assign conta_tempo = (estado == ASSENTANDO);
`endif
   assign limite = (estado == ENCHENDO) ? TW'(TIMEOUT_CYCLES - 1) : TW'(SETTLE_CYCLES - 1);

   temporizador_envase #(.W(TW)) u_temporizador (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .limpa    (prox_estado != estado),
      .conta    (conta_tempo),
      .limite   (limite),
      .terminal (terminal)
   );

   assign MOTOR_ESTEIRA     = (estado == AVANCANDO) || (estado == LIBERANDO);
   assign LIBERA_ENCHIMENTO = (estado == ENCHENDO);
   assign OCUPADO           = (estado != PARADO) && (estado != FALHA);
   assign LOTE_COMPLETO     = (estado == LOTE);
`ifdef FILL_TIMEOUT_EN
   assign ALARME            = (estado == FALHA);
`else
   assign ALARME            = 1'b0;
`endif

endmodule

// File: tb/tb_controle_linha_envase.sv
// Directed bench for controle_linha_envase with BATCH_SIZE=2, SETTLE=4, TIMEOUT=8.
module tb_controle_linha_envase;

   logic       CLOCK = 1'b0;
   logic       RESET;
   logic       START, STOP, SENSOR_POSICAO, GARRAFA_CHEIA;
   logic       MOTOR_ESTEIRA, LIBERA_ENCHIMENTO, OCUPADO, LOTE_COMPLETO, ALARME;
   logic [3:0] CONTAGEM;

   int errors = 0;
   int checks = 0;

   // {MOTOR, LIBERA, OCUPADO, LOTE_COMPLETO, ALARME}
   localparam logic [4:0] V_PARADO = 5'b00000;
   localparam logic [4:0] V_AVANC  = 5'b10100;
   localparam logic [4:0] V_ASSENT = 5'b00100;
   localparam logic [4:0] V_ENCH   = 5'b01100;
   localparam logic [4:0] V_LIBER  = 5'b10100;
   localparam logic [4:0] V_LOTE   = 5'b00110;
   localparam logic [4:0] V_FALHA  = 5'b00001;

   controle_linha_envase #(
      .BATCH_SIZE(2), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(8), .CNT_W(4)
   ) dut (
      .CLOCK(CLOCK), .RESET(RESET), .START(START), .STOP(STOP),
      .SENSOR_POSICAO(SENSOR_POSICAO), .GARRAFA_CHEIA(GARRAFA_CHEIA),
      .MOTOR_ESTEIRA(MOTOR_ESTEIRA), .LIBERA_ENCHIMENTO(LIBERA_ENCHIMENTO),
      .OCUPADO(OCUPADO), .CONTAGEM(CONTAGEM), .LOTE_COMPLETO(LOTE_COMPLETO),
      .ALARME(ALARME)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic step(input int n);
      repeat (n) @(posedge CLOCK);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [4:0] exp);
      logic [4:0] obs;
      obs = {MOTOR_ESTEIRA, LIBERA_ENCHIMENTO, OCUPADO, LOTE_COMPLETO, ALARME};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [3:0] exp);
      checks++;
      assert (CONTAGEM === exp) else begin
         errors++;
         $error("FAIL %s CONTAGEM observed=%0d expected=%0d", tag, CONTAGEM, exp);
      end
   endtask

   initial begin
      RESET = 1'b1; START = 1'b0; STOP = 1'b0; SENSOR_POSICAO = 1'b0; GARRAFA_CHEIA = 1'b0;
      step(2);
      chk_out("reset_out", V_PARADO);
      chk_cnt("reset_cnt", 4'd0);
      RESET = 1'b0;
      step(1);
      chk_out("idle", V_PARADO);

      // 1: two bottles fill a crate of two
      START = 1'b1; step(1); START = 1'b0;
      chk_out("t1_avanc", V_AVANC);
      SENSOR_POSICAO = 1'b1; step(1);
      chk_out("t1_assent0", V_ASSENT);
      for (int i = 1; i < 4; i++) begin
         step(1);
         chk_out("t1_settle", V_ASSENT);
      end
      step(1);
      chk_out("t1_ench", V_ENCH);
      step(2);
      chk_out("t1_ench_wait", V_ENCH);
      chk_cnt("t1_cnt0", 4'd0);
      GARRAFA_CHEIA = 1'b1; step(1); GARRAFA_CHEIA = 1'b0;
      chk_out("t1_liber", V_LIBER);
      chk_cnt("t1_cnt1", 4'd1);
      step(1);
      chk_out("t1_liber_hold", V_LIBER);
      SENSOR_POSICAO = 1'b0; step(1);
      chk_out("t1_avanc2", V_AVANC);
      chk_cnt("t1_cnt1_kept", 4'd1);
      SENSOR_POSICAO = 1'b1; step(5);
      chk_out("t1_ench2", V_ENCH);
      GARRAFA_CHEIA = 1'b1; step(1); GARRAFA_CHEIA = 1'b0;
      chk_cnt("t1_cnt2", 4'd2);
      SENSOR_POSICAO = 1'b0; step(1);
      chk_out("t1_lote", V_LOTE);
      step(1);
      chk_out("t1_parado", V_PARADO);
      chk_cnt("t1_cnt_clr", 4'd0);
      step(1);
      chk_out("t1_pulse_once", V_PARADO);

      // 2: sensor glitch of two cycles falls back to conveying
      START = 1'b1; step(1); START = 1'b0;
      SENSOR_POSICAO = 1'b1; step(2);
      chk_out("t2_assent", V_ASSENT);
      SENSOR_POSICAO = 1'b0; step(1);
      chk_out("t2_back", V_AVANC);
      step(4);
      chk_out("t2_still_avanc", V_AVANC);

      // 3: STOP while filling lets the bottle finish, then halts without crate pulse
      SENSOR_POSICAO = 1'b1; step(5);
      chk_out("t3_ench", V_ENCH);
      STOP = 1'b1; step(1); STOP = 1'b0;
      chk_out("t3_ench_stop", V_ENCH);
      GARRAFA_CHEIA = 1'b1; step(1); GARRAFA_CHEIA = 1'b0;
      chk_out("t3_liber", V_LIBER);
      chk_cnt("t3_cnt", 4'd1);
      SENSOR_POSICAO = 1'b0; step(1);
      chk_out("t3_parado", V_PARADO);
      chk_cnt("t3_cnt_kept", 4'd1);

      // 4: START with STOP is ignored; reset while filling clears everything at once
      START = 1'b1; STOP = 1'b1; step(1);
      chk_out("t4_startstop", V_PARADO);
      STOP = 1'b0; step(1); START = 1'b0;
      chk_out("t4_avanc", V_AVANC);
      SENSOR_POSICAO = 1'b1; step(5);
      chk_out("t4_ench", V_ENCH);
      chk_cnt("t4_cnt_before", 4'd1);
      RESET = 1'b1; #1;
      chk_out("t4_async_out", V_PARADO);
      chk_cnt("t4_async_cnt", 4'd0);
      SENSOR_POSICAO = 1'b0;
      step(1); RESET = 1'b0; step(1);
      chk_out("t4_after_reset", V_PARADO);

`ifdef FILL_TIMEOUT_EN
      // 5: no full signal within the timeout raises the alarm
      START = 1'b1; step(1); START = 1'b0;
      SENSOR_POSICAO = 1'b1; step(5);
      chk_out("t5_ench", V_ENCH);
      step(7);
      chk_out("t5_ench_last", V_ENCH);
      step(1);
      chk_out("t5_falha", V_FALHA);
      chk_cnt("t5_cnt_held", 4'd0);
      STOP = 1'b1; step(1); STOP = 1'b0;
      chk_out("t5_ack", V_PARADO);

      // 6: full signal on the last timeout cycle wins over the fault
      START = 1'b1; step(1); START = 1'b0;
      step(5);
      chk_out("t6_ench", V_ENCH);
      step(7);
      GARRAFA_CHEIA = 1'b1; step(1); GARRAFA_CHEIA = 1'b0;
      chk_out("t6_liber", V_LIBER);
      chk_cnt("t6_cnt", 4'd1);
      SENSOR_POSICAO = 1'b0; step(1);
      chk_out("t6_avanc", V_AVANC);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
